// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_pkg
//  Purpose  : Shared pipeline constants (XLEN, NOP bubble, default reset PC).
//  Revision : 1.0  initial release
// ============================================================================
package riscv_pkg;
    localparam int          XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous FIFO of {pc, instr} entries with flush and count.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head_data,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_full;
    logic             w_wr_en;
    logic             w_rd_en;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == c_cw'(DEPTH));
    assign w_wr_en   = push && !w_full && !flush;
    assign w_rd_en   = pop && !empty && !flush;
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= push_data;
    end

    // The fetch credit scheme must never let a response arrive into a full buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && w_full && !flush));

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Purpose  : IF stage: PC, credit-limited imem requests, response buffering,
//             redirect flush with in-flight kill, NOP bubble when empty.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        if_id_write,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        fetch_misaligned
);
    localparam int c_cw  = $clog2(FIFO_DEPTH+1);
    localparam int c_cw1 = c_cw + 1;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_resp_pc;
    logic [c_cw-1:0] r_outstanding;
    logic [c_cw-1:0] r_kill;
    logic            r_misaligned;

    logic [c_cw-1:0] w_fifo_count;
    logic            w_fifo_empty;
    logic [63:0]     w_head;
    logic [c_cw:0]   w_inflight;
    logic            w_grant;
    logic            w_rsp;
    logic            w_kill_now;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_target;

    // Words in flight plus words buffered may never exceed the buffer size.
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
    assign imem_req   = !reset && !redirect && (w_inflight < c_cw1'(FIFO_DEPTH));
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req && imem_gnt;
    assign w_rsp      = imem_rvalid && (r_outstanding != '0);
    assign w_kill_now = (r_kill != '0);
    assign w_push     = w_rsp && !w_kill_now && !redirect;
    assign w_pop      = if_id_write && if_valid && !redirect;
    assign w_target   = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_kill        <= '0;
            r_misaligned  <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + c_cw'(w_grant) - c_cw'(w_rsp);
            r_misaligned  <= redirect && (redirect_pc[1:0] != 2'b00);
            if (redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                // Every request still in flight after this cycle is stale.
                r_kill     <= r_outstanding - c_cw'(w_rsp);
            end else begin
                if (w_grant)              r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)               r_resp_pc  <= r_resp_pc + 32'd4;
                if (w_rsp && w_kill_now)  r_kill     <= r_kill - c_cw'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data ({r_resp_pc, imem_rdata}),
        .pop       (w_pop),
        .flush     (redirect),
        .head_data (w_head),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign if_valid         = !w_fifo_empty;
    assign if_pc            = if_valid ? w_head[63:32] : 32'h0000_0000;
    assign if_instr         = if_valid ? w_head[31:0]  : NOP_INSTR;
    assign fetch_misaligned = r_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_unit
//  Purpose  : Scoreboard bench: random memory latency/grants, stalls, redirects.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;
    localparam logic [31:0] c_nop      = 32'h0000_0013;
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_id_write = 1'b1;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        fetch_misaligned;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;

    if_fetch_unit #(.RESET_PC(c_reset_pc), .FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_gnt         (imem_gnt),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .if_id_write      (if_id_write),
        .if_valid         (if_valid),
        .if_pc            (if_pc),
        .if_instr         (if_instr),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory model: in-order, fixed latency ----------------
    typedef struct { logic [31:0] addr; int unsigned due; } req_t;
    req_t        mem_q[$];
    int unsigned lat = 1;
    int unsigned gnt_pct = 100;
    int unsigned grant_cnt = 0;
    int unsigned straggler_cyc = 32'hFFFF_FFFF;

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        if (reset) begin
            mem_q.delete();
            imem_gnt = 1'b0;
        end else if (cyc == straggler_cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBAD0_BAD0;
            imem_gnt    = 1'b0;
        end else begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q[0].addr);
                void'(mem_q.pop_front());
            end
            imem_gnt = ($urandom_range(99) < gnt_pct);
            if (imem_req && imem_gnt) begin
                mem_q.push_back('{addr: imem_addr, due: cyc + lat});
                grant_cnt++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    task automatic new_stream(input logic [31:0] target);
        logic [31:0] base;
        base = {target[31:2], 2'b00};
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic        prev_red  = 1'b0;
    logic [31:0] prev_rpc  = 32'h0;

    initial begin : monitor
        logic [31:0] e;
        logic        exp_mis;
        forever begin
            @(negedge clk);
            #1;
            if (!reset) begin
                if (prev_wait && !redirect) begin
                    chk("req_held", {31'b0, imem_req}, 32'd1);
                    chk("addr_held", imem_addr, prev_addr);
                end
                prev_wait = imem_req && !imem_gnt;
                prev_addr = imem_addr;
            end else begin
                prev_wait = 1'b0;
            end
            if (!if_valid) begin
                chk("bubble_pc", if_pc, 32'h0);
                chk("bubble_instr", if_instr, c_nop);
            end
            exp_mis = !reset && prev_red && (prev_rpc[1:0] != 2'b00);
            chk("misaligned", {31'b0, fetch_misaligned}, {31'b0, exp_mis});
            prev_red = redirect && !reset;
            prev_rpc = redirect_pc;
            if (!reset && if_valid && if_id_write && !redirect) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_instr: got pc %h expected none", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_pc", if_pc, e);
                    chk("stream_instr", if_instr, mem_word(e));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset(input int unsigned l);
        reset    = 1'b1;
        redirect = 1'b0;
        lat      = l;
        tick();
        tick();
        new_stream(c_reset_pc);
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        new_stream(target);
        tick();
        redirect = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned g0;
        bit found;
        #1 reset = 1'b1;
        new_stream(c_reset_pc);
        sample();
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, c_nop);
        chk("rst_mis", {31'b0, fetch_misaligned}, 32'd0);

        // Back-to-back fetch with 1-cycle memory, no stalls.
        gnt_pct = 100; if_id_write = 1'b1;
        do_reset(1);
        for (int k = 1; k <= 6; k++) begin
            sample();
            chk("b2b_req", {31'b0, imem_req}, 32'd1);
            chk("b2b_addr", imem_addr, 32'(4 * (k - 1)));
            chk("b2b_valid", {31'b0, if_valid}, {31'b0, (k >= 3)});
            if (k >= 3) chk("b2b_pc", if_pc, 32'(4 * (k - 3)));
            tick();
        end

        // Stall: credit caps granted requests at the buffer depth.
        if_id_write = 1'b0;
        do_reset(1);
        g0 = grant_cnt;
        repeat (10) tick();
        chk("stall_grants", grant_cnt - g0, 32'd4);
        sample();
        chk("stall_req_low", {31'b0, imem_req}, 32'd0);
        chk("stall_pc", if_pc, 32'h0);
        tick();
        if_id_write = 1'b1;
        repeat (12) tick();

        // 3-cycle memory, redirect with two requests outstanding.
        do_reset(3);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_q.size() == 2) found = 1; else tick();
        end
        chk("wait_two_outstanding", {31'b0, found}, 32'd1);
        do_redirect(32'h0000_0100);
        sample();
        chk("redir_bubble", {31'b0, if_valid}, 32'd0);
        tick();
        repeat (20) tick();

        // Redirect coinciding with a response, then a second redirect.
        do_reset(2);
        repeat (3) tick();
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mem_q.size() > 0 && mem_q[0].due == cyc) found = 1; else tick();
        end
        chk("wait_rvalid_cycle", {31'b0, found}, 32'd1);
        do_redirect(32'h0000_0180);
        tick();
        do_redirect(32'h0000_0200);
        repeat (20) tick();
        chk("kill_zero", 32'(dut.r_kill), 32'd0);

        // Misaligned redirect target.
        do_redirect(32'h0000_0103);
        sample();
        chk("mis_pulse", {31'b0, fetch_misaligned}, 32'd1);
        tick();
        sample();
        chk("mis_single", {31'b0, fetch_misaligned}, 32'd0);
        tick();
        repeat (15) tick();

        // Reset mid-stream with three buffered entries, then a straggler.
        if_id_write = 1'b0;
        do_reset(1);
        repeat (4) tick();
        #1 reset = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_pc", if_pc, 32'h0);
        chk("midrst_instr", if_instr, c_nop);
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        tick();
        new_stream(c_reset_pc);
        if_id_write   = 1'b1;
        straggler_cyc = cyc;
        reset         = 1'b0;
        sample();
        chk("restart_addr", imem_addr, c_reset_pc);
        tick();
        repeat (20) tick();

        // Randomized segments: latency, grant rate, stalls, redirects (incl. wrap).
        for (int seg = 0; seg < 15; seg++) begin
            gnt_pct     = $urandom_range(100, 40);
            if_id_write = 1'b1;
            do_reset($urandom_range(3, 1));
            for (int c = 0; c < 80; c++) begin
                if_id_write = ($urandom_range(99) < 70);
                if ($urandom_range(99) < 5) begin
                    case ($urandom_range(2))
                        0:       do_redirect($urandom());
                        1:       do_redirect(32'hFFFF_FFF0 | 32'($urandom_range(15)));
                        default: do_redirect(32'($urandom_range(255)));
                    endcase
                end else begin
                    tick();
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage pipeline: owns the fetch PC, issues sequential requests to instruction memory, buffers in-order responses in a small FIFO, and presents {PC, instruction} to the IF/ID pipeline register. It handles redirects from EX (taken branch/jump) by flushing buffered words and discarding in-flight responses, and it honours the IF/ID write-enable as its back-pressure. When no instruction is available it drives a NOP bubble.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- FIFO_DEPTH, 4, fetch-buffer entries (power of two, >= 2); also the cap on outstanding + buffered words
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- imem_req  out  1  fetch request valid
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  request accepted this cycle (imem_req && imem_gnt)
- imem_rvalid  in  1  response valid, one cycle per accepted request, strictly in order
- imem_rdata  in  32  instruction word
- redirect  in  1  EX-stage redirect (taken branch/jump), single-cycle pulse
- redirect_pc  in  32  redirect target
- if_id_write  in  1  IF/ID accepts this cycle (low = stall)
- if_valid  out  1  FIFO head is a real instruction
- if_pc  out  32  head PC, 0 when !if_valid
- if_instr  out  32  head instruction, 32'h0000_0013 when !if_valid
- fetch_misaligned  out  1  one-cycle pulse: redirect_pc[1:0] != 0

## Operation
- State: fetch_pc (next request address), resp_pc (PC of next expected response), outstanding count, kill count, FIFO of {pc, instr}.
- Request: imem_req = !redirect && (outstanding + fifo_count < FIFO_DEPTH), using registered values; imem_addr = fetch_pc. On grant: fetch_pc += 4, outstanding++. While req && !gnt, addr held stable (a redirect may withdraw it).
- Response: on imem_rvalid, outstanding--. If kill > 0: drop, kill--. Else push {resp_pc, imem_rdata}, resp_pc += 4. Credit rule guarantees no overflow; push into a full FIFO is a design error (assert).
- Pop: when if_id_write && if_valid && !redirect.
- Redirect: target = {redirect_pc[31:2], 2'b00}; fetch_pc <= target, resp_pc <= target; FIFO flushed; kill <= outstanding (+1 if a grant lands this cycle, which cannot happen since req is low; −1 if rvalid arrives this cycle, that response being dropped). fetch_misaligned pulses if low bits nonzero.
- Redirect while kill > 0: kill accumulates per the same rule; no stale word may ever reach the FIFO.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 silently.
- Count widths: $clog2(FIFO_DEPTH+1) bits for outstanding, kill, fifo_count.
- imem_rvalid with outstanding == 0 (e.g. straggler after reset) is ignored.

## Timing
- Reset values: imem_req 0 during reset, fetch_pc = resp_pc = RESET_PC, counts 0, FIFO empty, if_valid 0, if_pc 0, if_instr 32'h0000_0013, fetch_misaligned 0.
- First request in the first cycle after reset deasserts.
- Latency: grant in cycle N, rvalid in N+L, if_valid/if_instr updated at N+L+1 (FIFO write registered, head read combinational).
- Throughput: one instruction/cycle sustained for L = 1 with FIFO_DEPTH 4 and no stalls.
- Redirect in cycle R: if_valid 0 at R+1; first request to target issued R+1; with L = 1, target instruction at if_instr at R+3.
- Stall: if_pc/if_instr held while !if_id_write; requests continue until credit exhausted.

## Structure
- Shared package riscv_pkg: NOP_INSTR = 32'h0000_0013, default RESET_PC, XLEN = 32.
- One sub-module: fetch_fifo (synchronous FIFO, 64-bit {pc,instr} entries, push/pop/flush, count, async active-high reset). Request/credit/kill logic stays in if_fetch_unit.

## Test plan
- Reset release, 1-cycle memory, if_id_write = 1 -> requests 0x0, 0x4, 0x8 back-to-back; if_valid from cycle 3 with one new PC per cycle, no bubbles.
- Hold if_id_write = 0 for 10 cycles -> exactly 4 requests granted then imem_req low; if_pc stays 0x0; release resumes 0x4, 0x8 in order, none lost or duplicated.
- 3-cycle memory latency, redirect to 0x100 with 2 requests outstanding -> both stale responses dropped, first if_valid word has if_pc 0x100.
- Redirect in the same cycle as an imem_rvalid, then second redirect to 0x200 two cycles later -> only 0x200 stream appears; kill returns to 0.
- redirect_pc = 0x103 -> fetch_misaligned pulse one cycle, fetch resumes at 0x100.
- Assert reset mid-stream with FIFO holding 3 entries -> outputs immediately NOP/0/invalid; straggler rvalid ignored; fetch restarts at RESET_PC.
